// File: rtl/pattern_alarm_monitor.sv
// Event counter and windowed alarm fed by the sequence detector's pattern level.
// Optional build macro PATTERN_ALARM_CNT_SAT_EN makes event_count saturate at 9999 instead of wrapping.
module pattern_alarm_monitor #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned THRESHOLD     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pattern,
  input  logic        clear,
  output logic [15:0] event_count,
  output logic        alarm,
  output logic        window_active
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned HIT_W = 4;
  localparam int unsigned BCD_W = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WINDOW = 2'd1;
  localparam logic [1:0] S_ALARM  = 2'd2;

  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [HIT_W-1:0] HIT_LIMIT  = HIT_W'(THRESHOLD);
  localparam bit               SINGLE_HIT = (THRESHOLD == 1);
  localparam logic [BCD_W-1:0] BCD_MAX    = 16'h9999;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] win_cnt, win_cnt_d;
  logic [HIT_W-1:0] hits, hits_d, hits_inc;
  logic [BCD_W-1:0] count_d;
  logic             pattern_q;
  logic             ev;

  // Decimal increment, ripple carry from units to thousands; 9999 rolls to 0000.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign ev       = pattern & ~pattern_q;
  assign hits_inc = hits + HIT_W'(1);

  // Display total advances on every event regardless of FSM state or clear.
  always_comb begin
    count_d = event_count;
    if (ev) begin
`ifdef PATTERN_ALARM_CNT_SAT_EN
      if (event_count != BCD_MAX) begin
        count_d = bcd_inc(event_count);
      end
`else
      count_d = bcd_inc(event_count);
`endif
    end
  end

  // Next-state: clear always dominates; a threshold hit beats window expiry.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt;
    hits_d    = hits;
    case (state_q)
      S_IDLE: begin
        if (ev && !clear) begin
          hits_d    = HIT_W'(1);
          win_cnt_d = '0;
          state_d   = SINGLE_HIT ? S_ALARM : S_WINDOW;
        end
      end
      S_WINDOW: begin
        if (clear) begin
          state_d   = S_IDLE;
          hits_d    = '0;
          win_cnt_d = '0;
        end else begin
          win_cnt_d = win_cnt + CNT_W'(1);
          if (ev && (hits_inc == HIT_LIMIT)) begin
            hits_d  = hits_inc;
            state_d = S_ALARM;
          end else if (win_cnt == WIN_LAST) begin
            // An event on the closing cycle restarts a fresh window with itself as first hit.
            if (ev) begin
              hits_d    = HIT_W'(1);
              win_cnt_d = '0;
            end else begin
              state_d   = S_IDLE;
              hits_d    = '0;
              win_cnt_d = '0;
            end
          end else if (ev) begin
            hits_d = hits_inc;
          end
        end
      end
      S_ALARM: begin
        if (clear) begin
          state_d   = S_IDLE;
          hits_d    = '0;
          win_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        hits_d    = '0;
        win_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      win_cnt       <= '0;
      hits          <= '0;
      pattern_q     <= 1'b0;
      event_count   <= '0;
      alarm         <= 1'b0;
      window_active <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt       <= win_cnt_d;
      hits          <= hits_d;
      pattern_q     <= pattern;
      event_count   <= count_d;
      alarm         <= (state_d == S_ALARM);
      window_active <= (state_d == S_WINDOW);
    end
  end

endmodule

// File: tb/tb_pattern_alarm_monitor.sv
// Directed bench for pattern_alarm_monitor with WINDOW_CYCLES=10, THRESHOLD=3.
module tb_pattern_alarm_monitor;

  logic        clock;
  logic        reset;
  logic        pattern;
  logic        clear;
  logic [15:0] event_count;
  logic        alarm;
  logic        window_active;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        p;
    logic        c;
    logic        r;
    logic [15:0] cnt;
    logic        a;
    logic        w;
  } vec_t;

  vec_t vecs[$];

  pattern_alarm_monitor #(
    .WINDOW_CYCLES(10),
    .THRESHOLD    (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pattern      (pattern),
    .clear        (clear),
    .event_count  (event_count),
    .alarm        (alarm),
    .window_active(window_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic p, input logic c, input logic r,
                     input logic [15:0] cnt, input logic a, input logic w);
    vec_t v;
    v.p = p; v.c = c; v.r = r; v.cnt = cnt; v.a = a; v.w = w;
    vecs.push_back(v);
  endtask

  // Inputs are applied before the edge; outputs are sampled 1 time unit after it.
  task automatic step(input logic p, input logic c, input logic r);
    pattern = p;
    clear   = c;
    reset   = r;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] cnt, input logic a, input logic w);
    compared++;
    if (event_count !== cnt || alarm !== a || window_active !== w) begin
      mismatched++;
      $display("FAIL %s: got count=%h alarm=%b window=%b, want count=%h alarm=%b window=%b",
               name, event_count, alarm, window_active, cnt, a, w);
    end
  endtask

  logic [15:0] exp_top;

  initial begin
    reset   = 1'b1;
    pattern = 1'b0;
    clear   = 1'b0;

    // Single pulse: window open for exactly 10 cycles.
    add(0, 0, 1, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0001, 0, 1);
    repeat (9) add(0, 0, 0, 16'h0001, 0, 1);
    add(0, 0, 0, 16'h0001, 0, 0);
    add(0, 0, 0, 16'h0001, 0, 0);
    // Level held 5 cycles counts once.
    add(0, 0, 1, 16'h0000, 0, 0);
    repeat (5) add(1, 0, 0, 16'h0001, 0, 1);
    add(0, 0, 0, 16'h0001, 0, 1);
    // Pulses at cycles 0,3,6 raise alarm; clear at cycle 20.
    add(0, 0, 1, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0001, 0, 1);
    add(0, 0, 0, 16'h0001, 0, 1);
    add(0, 0, 0, 16'h0001, 0, 1);
    add(1, 0, 0, 16'h0002, 0, 1);
    add(0, 0, 0, 16'h0002, 0, 1);
    add(0, 0, 0, 16'h0002, 0, 1);
    add(1, 0, 0, 16'h0003, 1, 0);
    repeat (13) add(0, 0, 0, 16'h0003, 1, 0);
    add(0, 1, 0, 16'h0003, 0, 0);
    add(0, 0, 0, 16'h0003, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].p, vecs[i].c, vecs[i].r);
      chk($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].a, vecs[i].w);
    end

    // Expiry, reopen later, and a third hit on the tenth window cycle.
    step(0, 0, 1); chk("t4_reset", 16'h0000, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    chk("t4_open", 16'h0002, 0, 1);
    step(0, 0, 0); chk("t4_expire", 16'h0002, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0); chk("t4_reopen", 16'h0003, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    chk("t4_prefinal", 16'h0004, 0, 1);
    step(1, 0, 0); chk("t4_final_alarm", 16'h0005, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0); chk("alarm_event_counts", 16'h0006, 1, 0);
    step(0, 1, 0); chk("alarm_clear", 16'h0006, 0, 0);

    // Second hit on the closing cycle restarts with hits=1, so a later hit does not alarm.
    step(0, 0, 1);
    step(1, 0, 0);
    repeat (9) step(0, 0, 0);
    step(1, 0, 0); chk("final_reopen", 16'h0002, 0, 1);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0); chk("reopen_hits1", 16'h0003, 0, 1);
    repeat (5) step(0, 0, 0);
    chk("reopen_still_open", 16'h0003, 0, 1);
    step(0, 0, 0); chk("reopen_expire", 16'h0003, 0, 0);

    // Reset mid-window, clear with event in WINDOW and in IDLE.
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0); chk("t6_hits2", 16'h0002, 0, 1);
    step(0, 0, 1); chk("t6_reset_mid", 16'h0000, 0, 0);
    step(1, 0, 0); chk("t6_fresh", 16'h0001, 0, 1);
    step(0, 0, 0);
    step(1, 1, 0); chk("t6_clear_ev", 16'h0002, 0, 0);
    step(1, 0, 0); chk("t6_held_no_ev", 16'h0002, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0); chk("idle_clear_ev", 16'h0003, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0); chk("idle_clear", 16'h0003, 0, 0);

    // Reset mid-alarm.
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0); chk("pre_reset_alarm", 16'h0006, 1, 0);
    step(1, 0, 1); chk("reset_mid_alarm", 16'h0000, 0, 0);
    step(1, 0, 0); chk("high_after_reset", 16'h0001, 0, 1);

    // Wrap or saturate at 9999.
    step(0, 0, 1);
    for (int i = 0; i < 9998; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    chk("preload_9998", 16'h9998, 1, 0);
    step(1, 0, 0);
    step(0, 0, 0); chk("reach_9999", 16'h9999, 1, 0);
`ifdef PATTERN_ALARM_CNT_SAT_EN
    exp_top = 16'h9999;
`else
    exp_top = 16'h0000;
`endif
    step(1, 0, 0); chk("past_9999", exp_top, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
